// File: rtl/abc_pkg.sv
// Shared types and constants for the A*B+C window accumulator slice.
// Build option ABC_ACC_SAT_EN (see abc_sat_add) selects saturating sums.
package abc_pkg;

  localparam int DATA_W        = 16;
  localparam int DEF_ACC_W     = 20;
  localparam int DEF_N_SAMPLES = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/abc_sat_add.sv
// Combinational accumulator adder: ACC_W + zero-extended DATA_W, with carry out.
// With ABC_ACC_SAT_EN defined the result clamps to all-ones on carry; otherwise it wraps.
module abc_sat_add
  import abc_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum,
  output logic              carry
);

  logic [ACC_W:0] raw;

  always_comb begin
    raw   = {1'b0, a} + (ACC_W+1)'(b);
    carry = raw[ACC_W];
`ifdef ABC_ACC_SAT_EN
    sum   = carry ? '1 : raw[ACC_W-1:0];
`else
    sum   = raw[ACC_W-1:0];
`endif
  end

endmodule

// File: rtl/abc_window_accumulator.sv
// Sums N_SAMPLES accepted in_data words into one window sum held on a valid/ready output.
// Build option ABC_ACC_SAT_EN (in abc_sat_add) makes the window sum saturate instead of wrap.
module abc_window_accumulator
  import abc_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int ACC_W     = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  sum_out,
  output logic              sum_ovf,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [7:0]        win_count,
  output acc_state_t        dbg_state
);

  // Handshake: a word moves on a rising edge only when its valid and ready are both
  // high; valid never waits on ready, and in_ready depends only on state and sum_ready.
  localparam logic [7:0] LAST_IDX = 8'(N_SAMPLES - 1);

  acc_state_t       state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             ovf_sticky, sticky_nxt;
  logic [7:0]       win_nxt;
  logic [ACC_W-1:0] sum_nxt;
  logic             sum_ovf_nxt, sum_valid_nxt;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;
  logic             in_xfer, out_xfer;

  abc_sat_add #(.ACC_W(ACC_W)) u_add (
    .a     (acc),
    .b     (in_data),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign in_ready  = (state != HOLD) || sum_ready;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = sum_valid && sum_ready;
  assign dbg_state = state;

  // acc is already zero in HOLD, so a sample taken there starts a fresh window.
  always_comb begin
    state_nxt     = state;
    acc_nxt       = acc;
    sticky_nxt    = ovf_sticky;
    win_nxt       = win_count;
    sum_nxt       = sum_out;
    sum_ovf_nxt   = sum_ovf;
    sum_valid_nxt = sum_valid;

    if (out_xfer) begin
      sum_valid_nxt = 1'b0;
      state_nxt     = IDLE;
    end

    if (in_xfer) begin
      if (win_count == LAST_IDX) begin
        sum_nxt       = add_sum;
        sum_ovf_nxt   = ovf_sticky | add_carry;
        sum_valid_nxt = 1'b1;
        acc_nxt       = '0;
        sticky_nxt    = 1'b0;
        win_nxt       = 8'd0;
        state_nxt     = HOLD;
      end else begin
        acc_nxt    = add_sum;
        sticky_nxt = ovf_sticky | add_carry;
        win_nxt    = win_count + 8'd1;
        state_nxt  = ACCUM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      win_count  <= 8'd0;
      sum_out    <= '0;
      sum_ovf    <= 1'b0;
      sum_valid  <= 1'b0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      ovf_sticky <= sticky_nxt;
      win_count  <= win_nxt;
      sum_out    <= sum_nxt;
      sum_ovf    <= sum_ovf_nxt;
      sum_valid  <= sum_valid_nxt;
    end
  end

endmodule

// File: tb/tb_abc_window_accumulator.sv
// Bench for abc_window_accumulator: a 4-sample and a 1-sample instance (ACC_W=16),
// directed windows plus random traffic against a window-sum reference model.
module tb_abc_window_accumulator;
  import abc_pkg::*;

  localparam int W  = 16;
  localparam int NA = 4;
  localparam int NB = 1;

`ifdef ABC_ACC_SAT_EN
  localparam logic [W:0] OVF_EXP = 17'h1FFFF;
`else
  localparam logic [W:0] OVF_EXP = 17'h10001;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a = 1'b1, iv_a = 1'b0, sr_a = 1'b1;
  logic [15:0] id_a = '0;
  logic        ir_a, ov_a, sv_a;
  logic [W-1:0] so_a;
  logic [7:0]  wc_a;
  acc_state_t  st_a;

  logic        rst_b = 1'b1, iv_b = 1'b0, sr_b = 1'b1;
  logic [15:0] id_b = '0;
  logic        ir_b, ov_b, sv_b;
  logic [W-1:0] so_b;
  logic [7:0]  wc_b;
  acc_state_t  st_b;

  abc_window_accumulator #(.N_SAMPLES(NA), .ACC_W(W)) u_dut_a (
    .clk(clk), .reset(rst_a), .in_data(id_a), .in_valid(iv_a), .in_ready(ir_a),
    .sum_out(so_a), .sum_ovf(ov_a), .sum_valid(sv_a), .sum_ready(sr_a),
    .win_count(wc_a), .dbg_state(st_a)
  );

  abc_window_accumulator #(.N_SAMPLES(NB), .ACC_W(W)) u_dut_b (
    .clk(clk), .reset(rst_b), .in_data(id_b), .in_valid(iv_b), .in_ready(ir_b),
    .sum_out(so_b), .sum_ovf(ov_b), .sum_valid(sv_b), .sum_ready(sr_b),
    .win_count(wc_b), .dbg_state(st_b)
  );

  // scoreboard / reference model state
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en[2];
  longint      m_total[2];
  int          m_cnt[2];
  bit          m_mv[2];
  logic [W:0]  exp_q0[$];
  logic [W:0]  exp_q1[$];
  logic [W:0]  last_sum[2];

  function automatic void check(string name, logic [31:0] act, logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endfunction

  // Result of a whole window from its true arithmetic total: {ovf, sum}.
  function automatic logic [W:0] window_result(longint total);
    logic ovf;
    logic [W-1:0] s;
    ovf = (total >= 65536);
`ifdef ABC_ACC_SAT_EN
    s = ovf ? '1 : W'(total);
`else
    s = W'(total);
`endif
    return {ovf, s};
  endfunction

  function automatic void step(int i, int n, logic rst, logic iv, logic [15:0] d, logic sr,
                               logic [W-1:0] so, logic ov, logic sv, logic ir,
                               logic [7:0] wc, acc_state_t st);
    logic [W:0] front;
    bit         have;
    bit         take_in;
    acc_state_t exp_st;
    string      p;
    p     = (i == 0) ? "a" : "b";
    have  = (i == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
    front = '0;
    if (have) front = (i == 0) ? exp_q0[0] : exp_q1[0];

    if (chk_en[i]) begin
      exp_st = m_mv[i] ? HOLD : ((m_cnt[i] == 0) ? IDLE : ACCUM);
      check({p, "_sum_valid"}, 32'(sv), 32'(m_mv[i]));
      check({p, "_in_ready"},  32'(ir), 32'(!m_mv[i] || sr));
      check({p, "_win_count"}, 32'(wc), 32'(m_cnt[i]));
      check({p, "_state"},     32'(st), 32'(exp_st));
      if (m_mv[i]) begin
        if (have) check({p, "_sum_ovf"}, 32'({ov, so}), 32'(front));
        else begin
          n_tests++;
          n_fail++;
          $display("FAIL %s_sum: got 0x%0h, expected no pending window", p, {ov, so});
        end
      end
    end

    if (rst) begin
      m_total[i] = 0;
      m_cnt[i]   = 0;
      m_mv[i]    = 1'b0;
      if (i == 0) exp_q0.delete(); else exp_q1.delete();
    end else begin
      take_in = iv && (!m_mv[i] || sr);
      if (m_mv[i] && sr) begin
        last_sum[i] = front;
        if (have) begin
          if (i == 0) void'(exp_q0.pop_front()); else void'(exp_q1.pop_front());
        end
        m_mv[i] = 1'b0;
      end
      if (take_in) begin
        m_total[i] += longint'(d);
        m_cnt[i]++;
        if (m_cnt[i] == n) begin
          if (i == 0) exp_q0.push_back(window_result(m_total[i]));
          else        exp_q1.push_back(window_result(m_total[i]));
          m_mv[i]    = 1'b1;
          m_total[i] = 0;
          m_cnt[i]   = 0;
        end
      end
    end
  endfunction

  // monitor: sample away from the rising edge, then advance the model by that edge
  always @(negedge clk) begin
    step(0, NA, rst_a, iv_a, id_a, sr_a, so_a, ov_a, sv_a, ir_a, wc_a, st_a);
    step(1, NB, rst_b, iv_b, id_b, sr_b, so_b, ov_b, sv_b, ir_b, wc_b, st_b);
  end

  // driver tasks: one call = one clock of input values
  task automatic drv_a(input logic v, input logic [15:0] d, input logic r, input logic rs = 1'b0);
    @(posedge clk);
    #1;
    iv_a = v; id_a = d; sr_a = r; rst_a = rs;
  endtask

  task automatic drv_b(input logic v, input logic [15:0] d, input logic r, input logic rs = 1'b0);
    @(posedge clk);
    #1;
    iv_b = v; id_b = d; sr_b = r; rst_b = rs;
  endtask

  function automatic logic [15:0] rnd_data();
    return ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 65535)) : 16'($urandom_range(0, 100));
  endfunction

  initial begin
    last_sum[0] = '0;
    last_sum[1] = '0;
    fork
      begin : seq_a
        drv_a(0, 0, 1, 1);
        drv_a(0, 0, 1, 1);
        chk_en[0] = 1'b1;
        // basic window
        drv_a(1, 10, 1); drv_a(1, 20, 1); drv_a(1, 30, 1); drv_a(1, 40, 1);
        drv_a(0, 0, 1);  drv_a(0, 0, 1);
        check("a_basic_sum", 32'(last_sum[0]), 32'd100);
        // backpressure, then accept-and-release on the same edge
        drv_a(1, 1, 0); drv_a(1, 1, 0); drv_a(1, 1, 0); drv_a(1, 1, 0);
        drv_a(1, 9, 0); drv_a(1, 9, 0); drv_a(1, 9, 0);
        drv_a(1, 5, 1); drv_a(0, 0, 1);
        check("a_bp_sum", 32'(last_sum[0]), 32'd4);
        drv_a(1, 0, 1); drv_a(1, 0, 1); drv_a(1, 0, 1); drv_a(0, 0, 1); drv_a(0, 0, 1);
        check("a_bp_next_sum", 32'(last_sum[0]), 32'd5);
        // gaps
        for (int k = 1; k <= 4; k++) begin
          drv_a(1, 16'(k), 1);
          drv_a(0, 16'hdead, 1);
        end
        drv_a(0, 0, 1);
        check("a_gap_sum", 32'(last_sum[0]), 32'd10);
        // overflow
        drv_a(1, 16'hffff, 1); drv_a(1, 16'h0002, 1); drv_a(1, 0, 1); drv_a(1, 0, 1);
        drv_a(0, 0, 1); drv_a(0, 0, 1);
        check("a_ovf_sum", 32'(last_sum[0]), 32'(OVF_EXP));
        // reset mid-window
        drv_a(1, 3, 1); drv_a(1, 3, 1);
        drv_a(1, 9, 1, 1);
        drv_a(1, 1, 1);
        check("a_rst_sum_out", 32'(so_a), 32'd0);
        check("a_rst_sum_ovf", 32'(ov_a), 32'd0);
        check("a_rst_sum_valid", 32'(sv_a), 32'd0);
        check("a_rst_win_count", 32'(wc_a), 32'd0);
        drv_a(1, 1, 1); drv_a(1, 1, 1); drv_a(1, 1, 1);
        drv_a(0, 0, 1); drv_a(0, 0, 1);
        check("a_rst_then_sum", 32'(last_sum[0]), 32'd4);
        // random traffic with occasional resets
        for (int k = 0; k < 600; k++)
          drv_a($urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 3) != 0,
                $urandom_range(0, 99) == 0);
        drv_a(0, 0, 1);
      end
      begin : seq_b
        drv_b(0, 0, 1, 1);
        drv_b(0, 0, 1, 1);
        chk_en[1] = 1'b1;
        drv_b(1, 7, 1); drv_b(1, 8, 1); drv_b(1, 9, 1);
        drv_b(0, 0, 1); drv_b(0, 0, 1);
        check("b_stream_last", 32'(last_sum[1]), 32'd9);
        for (int k = 0; k < 400; k++)
          drv_b($urandom_range(0, 2) != 0, rnd_data(), $urandom_range(0, 2) != 0);
        drv_b(0, 0, 1);
      end
    join
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
